// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared encodings, defaults and sizing helpers for the LSTM memories
package lstm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam int DEF_WIDTH          = 32;
   localparam int DEF_NUM            = 68;
   localparam int DEF_NUM_ITERATIONS = 8;
   localparam int DEF_DEPTH          = DEF_NUM * DEF_NUM_ITERATIONS;

   // Never return 0 so degenerate sizes still give a legal vector width.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/ram_sdp_rbw.sv
// rtl/ram_sdp_rbw.sv - simple dual-port RAM, registered read, read-before-write
module ram_sdp_rbw
   import lstm_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = clog2_min1(DEF_DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Both updates are non-blocking, so a same-address read sees the old word.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_output_y.sv
// rtl/mem_output_y.sv - sequential capture memory for LSTM outputs with random-access read
module mem_output_y
   import lstm_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int NUM            = DEF_NUM,
   parameter int NUM_ITERATIONS = DEF_NUM_ITERATIONS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             iter_done,
   output logic             done,
   input  logic [WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid
);

   localparam int DEPTH = NUM * NUM_ITERATIONS;
   localparam int AW    = clog2_min1(DEPTH);
   localparam int SW    = clog2_min1(NUM);
   localparam int IW    = clog2_min1(NUM_ITERATIONS + 1);

   localparam logic [SW-1:0]    STEP_LAST = SW'(NUM - 1);
   localparam logic [IW-1:0]    ITER_LAST = IW'(NUM_ITERATIONS - 1);
   localparam logic [WIDTH-1:0] DEPTH_W   = WIDTH'(DEPTH);

   state_e          state_q, state_d;
   logic [SW-1:0]   step_q, step_d;
   logic [IW-1:0]   iter_q, iter_d;
   logic            iter_done_q, iter_done_d;
   logic            rd_valid_q;
   logic            accept;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic            rd_in_range;
   logic [AW-1:0]   ram_rd_addr;
   logic [WIDTH-1:0] ram_rd_data;

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      iter_d      = iter_q;
      iter_done_d = 1'b0;
      wr_en       = 1'b0;
      accept      = in_valid && (state_q == CAPTURE);
      // start wins over a simultaneous accept: counters clear and nothing is written.
      if (start) begin
         state_d = CAPTURE;
         step_d  = '0;
         iter_d  = '0;
      end else if (accept) begin
         wr_en = 1'b1;
         if (step_q == STEP_LAST) begin
            step_d      = '0;
            iter_d      = iter_q + IW'(1);
            iter_done_d = 1'b1;
            if (iter_q == ITER_LAST) begin
               state_d = DONE;
            end
         end else begin
            step_d = step_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         step_q      <= '0;
         iter_q      <= '0;
         iter_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         iter_q      <= iter_d;
         iter_done_q <= iter_done_d;
         rd_valid_q  <= rd_in_range;
      end
   end

   assign wr_addr     = AW'(iter_q) * AW'(NUM) + AW'(step_q);
   assign rd_in_range = (rd_addr < DEPTH_W);
   assign ram_rd_addr = rd_in_range ? rd_addr[AW-1:0] : '0;

   ram_sdp_rbw #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (in_data),
      .raddr_i (ram_rd_addr),
      .rdata_o (ram_rd_data)
   );

   // rd_valid_q is registered and async-cleared, so the masked output is registered too.
   assign rd_data   = rd_valid_q ? ram_rd_data : '0;
   assign rd_valid  = rd_valid_q;
   assign in_ready  = (state_q == CAPTURE);
   assign iter_done = iter_done_q;
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_output_y.sv
// tb/tb_mem_output_y.sv - directed self-checking bench for mem_output_y (NUM=4, NUM_ITERATIONS=2)
module tb_mem_output_y;

   localparam int WIDTH = 32;
   localparam int NUM   = 4;
   localparam int NITER = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             iter_done;
   logic             done;
   logic [WIDTH-1:0] rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_output_y #(
      .WIDTH          (WIDTH),
      .NUM            (NUM),
      .NUM_ITERATIONS (NITER)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .iter_done (iter_done),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h99;
      rd_addr  = 32'd8;

      // Reset and idle: no start, so nothing is accepted.
      tick();
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_ready", {31'd0, in_ready}, 32'd0);
         check("idle_done", {31'd0, done}, 32'd0);
         check("idle_rd_data", rd_data, 32'd0);
         check("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
      end

      // Full run of 8 words.
      in_valid = 1'b0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("run_ready", {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h10 + k;
         tick();
         check("run_iter_done", {31'd0, iter_done}, (k == 3 || k == 7) ? 32'd1 : 32'd0);
         check("run_done", {31'd0, done}, (k == 7) ? 32'd1 : 32'd0);
      end
      check("full_ready", {31'd0, in_ready}, 32'd0);

      // Words after done are refused.
      in_data = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ovf_ready", {31'd0, in_ready}, 32'd0);
         check("ovf_done", {31'd0, done}, 32'd1);
         check("ovf_iter_done", {31'd0, iter_done}, 32'd0);
      end
      in_valid = 1'b0;

      for (int a = 0; a <= 8; a++) begin
         rd_addr = a;
         tick();
         check("run_rd_data", rd_data, (a < 8) ? 32'h10 + a : 32'd0);
         check("run_rd_valid", {31'd0, rd_valid}, (a < 8) ? 32'd1 : 32'd0);
      end

      // Restart: start together with a valid word at step 2.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rs_done_clr", {31'd0, done}, 32'd0);
      in_valid = 1'b1;
      in_data  = 32'h20;
      tick();
      in_data = 32'h21;
      tick();
      start   = 1'b1;
      in_data = 32'hAA;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      check("rs_ready", {31'd0, in_ready}, 32'd1);
      check("rs_iter_done", {31'd0, iter_done}, 32'd0);
      rd_addr = 32'd2;
      tick();
      check("rs_no_write", rd_data, 32'h12);
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h30 + k;
         tick();
         check("rs_done", {31'd0, done}, (k == 7) ? 32'd1 : 32'd0);
      end
      in_valid = 1'b0;
      for (int a = 0; a < 8; a++) begin
         rd_addr = a;
         tick();
         check("rs_rd_data", rd_data, 32'h30 + a);
      end

      // Read/write collision at addr 5.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h40 + k;
         tick();
      end
      in_data = 32'h55;
      rd_addr = 32'd5;
      tick();
      check("col_old", rd_data, 32'h35);
      in_valid = 1'b0;
      tick();
      check("col_new", rd_data, 32'h55);

      // Asynchronous reset after 3 accepts of a fresh run.
      start = 1'b1;
      tick();
      start   = 1'b0;
      rd_addr = 32'd0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h60 + k;
         tick();
      end
      in_valid = 1'b0;
      check("ar_pre_valid", {31'd0, rd_valid}, 32'd1);
      #3;
      rst = 1'b0;
      #1;
      check("ar_ready", {31'd0, in_ready}, 32'd0);
      check("ar_done", {31'd0, done}, 32'd0);
      check("ar_iter_done", {31'd0, iter_done}, 32'd0);
      check("ar_rd_data", rd_data, 32'd0);
      check("ar_rd_valid", {31'd0, rd_valid}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("ar_idle_ready", {31'd0, in_ready}, 32'd0);
      for (int a = 0; a < 4; a++) begin
         rd_addr = a;
         tick();
         check("ar_rd_data_kept", rd_data, (a < 3) ? 32'h60 + a : 32'h43);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_output_y.md
# mem_output_y

Capture memory for LSTM forward-propagation outputs, the write-side counterpart of the label ROM.
- Accepts one signed output word per handshake and stores it sequentially, NUM words per iteration over NUM_ITERATIONS iterations.
- Exposes a registered random-access read port, so the error/backprop stage can compare stored predictions against labels at the same address.

## Interface
Parameters:
- WIDTH, 32, data and read-address width
- NUM, 68, words per iteration (features + 1)
- NUM_ITERATIONS, 8, iterations per capture run; memory depth DEPTH = NUM*NUM_ITERATIONS

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin (or restart) a capture run
- in_valid  input  1  in_data is valid
- in_data  input  WIDTH  signed output word from the LSTM
- in_ready  output  1  block accepts a word this cycle
- iter_done  output  1  one-cycle pulse after the last word of each iteration is stored
- done  output  1  level; the run is complete and the memory is full
- rd_addr  input  WIDTH  read address; the same linear map as the write side, iteration*NUM + step
- rd_data  output  WIDTH  signed read data, registered
- rd_valid  output  1  rd_data corresponds to an in-range address

## Operation
- States:
  - IDLE: after reset; not accepting.
  - CAPTURE: accepting words.
  - DONE: memory full.
- Transitions:
  - IDLE → CAPTURE on start.
  - CAPTURE → DONE on acceptance of word DEPTH-1.
  - DONE → CAPTURE on start.
  - start in CAPTURE restarts the run at step 0, iteration 0.
- in_ready = (state == CAPTURE); it is combinational from state only.
- A word is accepted when in_valid and in_ready are both high at a clk edge.
- On acceptance, mem[iter*NUM + step] ← in_data. Then step increments. When step == NUM-1, step wraps to 0 and iter increments.
- Priority: start beats an accept in the same cycle. The counters clear, no write occurs, and state becomes CAPTURE.
- Words presented in IDLE or DONE are not accepted (in_ready=0). They are never written.
- iter_done pulses on the cycle after the accept where step == NUM-1. This includes the final iteration, where it coincides with done rising.
- done is cleared by start.
- Memory contents are not cleared by reset or start. Only control state resets.
- Read side:
  - rd_data ← mem[rd_addr] every cycle.
  - If rd_addr ≥ DEPTH: rd_data ← 0 and rd_valid ← 0; otherwise rd_valid ← 1.
- Read is independent of state, including during capture.
- Read and write to the same address in the same cycle returns the old data (read-before-write).
- Reset values: state IDLE, step 0, iter 0, in_ready 0, iter_done 0, done 0, rd_data 0, rd_valid 0.
- Asserting rst mid-run aborts immediately. The partially written memory is retained.

## Timing
- Write latency: a word accepted at edge N is readable with rd_addr applied before edge N+1, and appears on rd_data after edge N+1.
- Read latency: 1 cycle from rd_addr to rd_data/rd_valid.
- Back-to-back accepts are allowed every cycle. Peak throughput is 1 word/clk, so a full run takes DEPTH accepting cycles.
- done and the DONE state take effect at the edge accepting word DEPTH-1; in_ready drops in the following cycle.
- start is sampled at the edge; in_ready rises in the cycle after start.

## Structure
- Shared package (lstm_pkg):
  - state encodings IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2
  - default WIDTH/NUM/NUM_ITERATIONS values
  - a DEPTH helper constant
- Counter widths: step uses clog2(NUM), iter uses clog2(NUM_ITERATIONS+1).
- One sub-module, ram_sdp_rbw, holds the array: a simple dual-port RAM with one write port, one registered read port and read-before-write behaviour.
- mem_output_y holds the FSM, the counters, address generation and range checking.

## Test plan
- Reset/idle:
  - Stimulus: hold rst low, then release; drive in_valid=1 with no start.
  - Required: in_ready=0, done=0, rd_data=0 and rd_valid=0 throughout.
- Full run:
  - Stimulus: NUM=4, NUM_ITERATIONS=2; start, then 8 consecutive words 0x10..0x17.
  - Required: iter_done pulses after the 4th and 8th accepts; done rises with the 8th.
  - Required: reads of addr 0..7 return 0x10..0x17; addr 8 returns 0 with rd_valid=0.
- Backpressure/overflow:
  - Stimulus: after done, present 0xDEAD for 3 cycles.
  - Required: in_ready=0 and memory unchanged; addr 7 still reads 0x17.
- Restart priority:
  - Stimulus: mid-run at step 2, assert start together with in_valid (data 0xAA).
  - Required: no write; the next accepted word lands at addr 0; done stays 0 until 8 new accepts.
- Async reset mid-run:
  - Stimulus: drop rst between edges after 3 accepts.
  - Required: outputs zero immediately, state IDLE.
  - Required: addr 0..2 still read their stored values after reset release.
- Read/write collision:
  - Stimulus: while writing 0x55 to addr 5, set rd_addr=5.
  - Required: the next rd_data is the old addr-5 contents; the following cycle it returns 0x55.
